multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback sequencing with bus timeout and illegal-op traps.
// Memory accesses hold mem_req until mem_ready; define RV_UTYPE_EN to add LUI/AUIPC (U_EXEC state).
module multicycle_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op_code,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_w,
   output logic             adr_src,
   output logic             ir_w,
   output logic             pc_w,
   output logic             reg_w,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       imm_src,
   output logic [1:0]       result_src,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef RV_UTYPE_EN
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;

   typedef enum logic [3:0] {
      S_BOOT, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL,
`ifdef RV_UTYPE_EN
      S_U_EXEC,
`endif
      S_TRAP
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        cause_nx;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_st;
   logic              timed_out;
   logic              br_ok;
   logic              br_taken;
   logic              fetch_q;
   logic              branch_q;
   logic              jal_q;

   assign wait_st   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timed_out = (TIMEOUT != 0) && wait_st && !mem_ready && (wait_cnt == WAIT_LAST);

   assign br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

   // Strobes that must coincide with a same-cycle input are qualified here; everything else is registered.
   assign ir_w = fetch_q & mem_ready;
   assign pc_w = (fetch_q & mem_ready) | jal_q | (branch_q & br_taken);

   always_comb begin
      state_nx = state;
      cause_nx = trap_cause;
      case (state)
         S_BOOT:    state_nx = S_FETCH;
         S_FETCH:   if (mem_ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (op_code)
               OP_LOAD, OP_STORE: state_nx = S_MEM_ADR;
               OP_R:              state_nx = S_EXEC_R;
               OP_I:              state_nx = S_EXEC_I;
               OP_BR:             state_nx = S_BRANCH;
               OP_JAL:            state_nx = S_JAL;
`ifdef RV_UTYPE_EN
               OP_LUI, OP_AUIPC:  state_nx = S_U_EXEC;
`endif
               default: begin
                  state_nx = S_TRAP;
                  cause_nx = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEM_ADR: state_nx = (op_code == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  if (mem_ready) state_nx = S_MEM_WB;
         S_MEM_WB:  state_nx = S_FETCH;
         S_MEM_WR:  if (mem_ready) state_nx = S_FETCH;
         S_EXEC_R:  state_nx = S_ALU_WB;
         S_EXEC_I:  state_nx = S_ALU_WB;
         S_ALU_WB:  state_nx = S_FETCH;
         S_BRANCH: begin
            if (br_ok) begin
               state_nx = S_FETCH;
            end else begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_ILLEGAL;
            end
         end
         S_JAL:     state_nx = S_ALU_WB;
`ifdef RV_UTYPE_EN
         S_U_EXEC:  state_nx = S_ALU_WB;
`endif
         S_TRAP:    state_nx = S_TRAP;
         default:   state_nx = S_TRAP;
      endcase
      if (timed_out) begin
         state_nx = S_TRAP;
         cause_nx = CAUSE_BUS;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_BOOT;
         wait_cnt   <= '0;
         instret    <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
         mem_req    <= 1'b0;
         mem_w      <= 1'b0;
         adr_src    <= 1'b0;
         reg_w      <= 1'b0;
         alu_src_a  <= 2'b00;
         alu_src_b  <= 2'b00;
         alu_op     <= 2'b00;
         imm_src    <= 3'b000;
         result_src <= 2'b00;
         fetch_q    <= 1'b0;
         branch_q   <= 1'b0;
         jal_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         trap_cause <= cause_nx;

         if (state_nx != state)
            wait_cnt <= '0;
         else if (wait_st && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;

         if ((state_nx == S_FETCH) && (state != S_FETCH) && (state != S_BOOT))
            instret <= instret + CNT_W'(1);

         // Outputs are decoded from the upcoming state so they are valid from the first cycle of it.
         mem_req    <= 1'b0;
         mem_w      <= 1'b0;
         adr_src    <= 1'b0;
         reg_w      <= 1'b0;
         alu_src_a  <= 2'b00;
         alu_src_b  <= 2'b00;
         alu_op     <= 2'b00;
         imm_src    <= 3'b000;
         result_src <= 2'b00;
         fetch_q    <= 1'b0;
         branch_q   <= 1'b0;
         jal_q      <= 1'b0;
         trap       <= 1'b0;
         case (state_nx)
            S_FETCH: begin
               mem_req    <= 1'b1;
               alu_src_b  <= 2'b10;
               result_src <= 2'b10;
               fetch_q    <= 1'b1;
            end
            S_DECODE: begin
               alu_src_a <= 2'b01;
               alu_src_b <= 2'b01;
               imm_src   <= 3'b010;
            end
            S_MEM_ADR: begin
               alu_src_a <= 2'b10;
               alu_src_b <= 2'b01;
               imm_src   <= (op_code == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEM_RD: begin
               mem_req <= 1'b1;
               adr_src <= 1'b1;
            end
            S_MEM_WB: begin
               result_src <= 2'b01;
               reg_w      <= 1'b1;
            end
            S_MEM_WR: begin
               mem_req <= 1'b1;
               mem_w   <= 1'b1;
               adr_src <= 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a <= 2'b10;
               alu_op    <= 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a <= 2'b10;
               alu_src_b <= 2'b01;
               alu_op    <= 2'b10;
            end
            S_ALU_WB: reg_w <= 1'b1;
            S_BRANCH: begin
               alu_src_a <= 2'b10;
               alu_op    <= 2'b01;
               branch_q  <= 1'b1;
            end
            S_JAL: begin
               alu_src_a <= 2'b01;
               alu_src_b <= 2'b10;
               jal_q     <= 1'b1;
            end
`ifdef RV_UTYPE_EN
            S_U_EXEC: begin
               alu_src_a <= (op_code == OP_LUI) ? 2'b11 : 2'b01;
               alu_src_b <= 2'b01;
               imm_src   <= 3'b100;
            end
`endif
            S_TRAP:  trap <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
